// File: rtl/video_gen_pkg.sv
// Shared types and constants for the AXI-Stream video frame generator.
// The VIDEO_GEN_NOISE_EN build uses the LFSR seed/taps below for pattern 3.
package video_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FLAT    = 2'd3
  } pattern_e;

  localparam int unsigned PIX_W     = 8;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 expressed as a mask over state bits [7:0]
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Pixel value for the pixel about to be presented. With VIDEO_GEN_NOISE_EN
// pattern 3 is an LFSR stream; otherwise it is a flat frame of frame_cnt[7:0].
module video_pattern_gen
  import video_gen_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_adv,
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic [7:0] i_frame_cnt,
  input  logic [1:0] i_sel,
  output logic [7:0] o_pix_c
);

  logic [7:0] w_noise;

`ifdef VIDEO_GEN_NOISE_EN
  logic [7:0] r_lfsr;
  logic       w_unused;

  assign w_unused = ^i_frame_cnt;

  // Reseed wins over advance so a back-to-back frame still begins at the seed
  always_comb begin
    w_noise = r_lfsr;
    if (i_start) begin
      w_noise = LFSR_SEED;
    end else if (i_adv) begin
      w_noise = lfsr_step(r_lfsr);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_noise;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{i_clk, i_rst_n, i_start, i_adv};
  assign w_noise  = i_frame_cnt;
`endif

  always_comb begin
    o_pix_c = 8'h00;
    case (pattern_e'(i_sel))
      PAT_HRAMP:   o_pix_c = i_x;
      PAT_VRAMP:   o_pix_c = i_y;
      PAT_CHECKER: o_pix_c = (i_x[3] ^ i_y[3]) ? 8'hFF : 8'h00;
      PAT_FLAT:    o_pix_c = w_noise;
      default:     o_pix_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/axis_video_frame_gen.sv
// AXI-Stream test-pattern frame source with programmable size and blanking.
// Define VIDEO_GEN_NOISE_EN to turn pattern 3 into an LFSR noise frame.
module axis_video_frame_gen
  import video_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DIM_WIDTH   = 12,
  parameter int unsigned BLANK_WIDTH = 16
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_aresetn,
  input  logic                   en_module,
  input  logic [DIM_WIDTH-1:0]   frame_width_param,
  input  logic [DIM_WIDTH-1:0]   frame_height_param,
  input  logic [BLANK_WIDTH-1:0] hblank_param,
  input  logic [BLANK_WIDTH-1:0] vblank_param,
  input  logic [1:0]             pattern_sel,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt
);

  state_e                 r_state, w_state_nxt;
  logic [DIM_WIDTH-1:0]   r_x, r_y, r_w, r_h;
  logic [DIM_WIDTH-1:0]   w_x_nxt, w_y_nxt, w_w_nxt, w_h_nxt;
  logic [BLANK_WIDTH-1:0] r_hb, r_vb, r_bcnt;
  logic [BLANK_WIDTH-1:0] w_hb_nxt, w_vb_nxt, w_bcnt_nxt;
  logic [1:0]             r_sel, w_sel_nxt;
  logic [15:0]            r_frame_cnt, w_frame_cnt_nxt;
  logic                   r_frame_done, w_frame_done_nxt;
  logic                   r_tvalid, r_tuser, r_tlast;
  logic                   w_tvalid_nxt, w_tuser_nxt, w_tlast_nxt;
  logic [DATA_WIDTH-1:0]  r_tdata, w_tdata_nxt;

  logic                   w_xfer, w_last_x, w_last_y, w_can_start;
  logic                   w_load, w_latch, w_boundary, w_frame_start;
  logic [DIM_WIDTH-1:0]   w_ld_x, w_ld_y;
  logic [7:0]             w_pix;

  assign w_xfer      = r_tvalid & m_axis_tready;
  assign w_last_x    = (r_x == r_w - DIM_WIDTH'(1));
  assign w_last_y    = (r_y == r_h - DIM_WIDTH'(1));
  assign w_can_start = en_module && (frame_width_param != '0) && (frame_height_param != '0);

  // Next-state and counter control; w_load marks an output-register reload
  always_comb begin
    w_state_nxt      = r_state;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_w_nxt          = r_w;
    w_h_nxt          = r_h;
    w_hb_nxt         = r_hb;
    w_vb_nxt         = r_vb;
    w_sel_nxt        = r_sel;
    w_bcnt_nxt       = r_bcnt;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;
    w_latch          = 1'b0;
    w_boundary       = 1'b0;
    w_frame_start    = 1'b0;
    w_ld_x           = r_x;
    w_ld_y           = r_y;

    case (r_state)
      IDLE: begin
        if (w_can_start) begin
          w_latch     = 1'b1;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = ACTIVE;
        end
      end

      ACTIVE: begin
        if (!r_tvalid) begin
          w_load        = 1'b1;
          w_frame_start = 1'b1;
        end else if (w_xfer) begin
          if (!w_last_x) begin
            w_x_nxt = r_x + DIM_WIDTH'(1);
            w_load  = 1'b1;
            w_ld_x  = w_x_nxt;
          end else begin
            w_x_nxt = '0;
            if (w_last_y) begin
              w_frame_done_nxt = 1'b1;
              w_frame_cnt_nxt  = r_frame_cnt + 16'd1;
              w_y_nxt          = '0;
              if (r_vb == '0) begin
                w_boundary = 1'b1;
              end else begin
                w_bcnt_nxt  = '0;
                w_state_nxt = VBLANK;
              end
            end else begin
              w_y_nxt = r_y + DIM_WIDTH'(1);
              if (r_hb == '0) begin
                w_load = 1'b1;
                w_ld_x = '0;
                w_ld_y = w_y_nxt;
              end else begin
                w_bcnt_nxt  = '0;
                w_state_nxt = HBLANK;
              end
            end
          end
        end
      end

      // Reload on the last blank cycle so the idle gap is exactly hblank long
      HBLANK: begin
        if (r_bcnt == r_hb - BLANK_WIDTH'(1)) begin
          w_load      = 1'b1;
          w_ld_x      = '0;
          w_ld_y      = r_y;
          w_state_nxt = ACTIVE;
        end else begin
          w_bcnt_nxt = r_bcnt + BLANK_WIDTH'(1);
        end
      end

      VBLANK: begin
        if (r_bcnt == r_vb - BLANK_WIDTH'(1)) begin
          w_boundary = 1'b1;
        end else begin
          w_bcnt_nxt = r_bcnt + BLANK_WIDTH'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    // Frame boundary: continue straight into a freshly configured frame or park
    if (w_boundary) begin
      if (w_can_start) begin
        w_latch       = 1'b1;
        w_x_nxt       = '0;
        w_y_nxt       = '0;
        w_load        = 1'b1;
        w_frame_start = 1'b1;
        w_ld_x        = '0;
        w_ld_y        = '0;
        w_state_nxt   = ACTIVE;
      end else begin
        w_state_nxt = IDLE;
      end
    end

    if (w_latch) begin
      w_w_nxt   = frame_width_param;
      w_h_nxt   = frame_height_param;
      w_hb_nxt  = hblank_param;
      w_vb_nxt  = vblank_param;
      w_sel_nxt = pattern_sel;
    end
  end

  video_pattern_gen u_pattern (
    .i_clk       (i_sys_clk),
    .i_rst_n     (i_sys_aresetn),
    .i_start     (w_frame_start),
    .i_adv       (w_xfer),
    .i_x         (w_ld_x[7:0]),
    .i_y         (w_ld_y[7:0]),
    .i_frame_cnt (w_frame_cnt_nxt[7:0]),
    .i_sel       (w_sel_nxt),
    .o_pix_c     (w_pix)
  );

  // Output beat: hold while stalled, reload on transfer or when empty
  always_comb begin
    w_tvalid_nxt = r_tvalid;
    w_tdata_nxt  = r_tdata;
    w_tuser_nxt  = r_tuser;
    w_tlast_nxt  = r_tlast;
    if (w_load) begin
      w_tvalid_nxt = 1'b1;
      w_tdata_nxt  = DATA_WIDTH'(w_pix);
      w_tuser_nxt  = (w_ld_x == '0) && (w_ld_y == '0);
      w_tlast_nxt  = (w_ld_x == w_w_nxt - DIM_WIDTH'(1));
    end else if (w_xfer) begin
      w_tvalid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_x          <= '0;
      r_y          <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_hb         <= '0;
      r_vb         <= '0;
      r_sel        <= '0;
      r_bcnt       <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_w          <= w_w_nxt;
      r_h          <= w_h_nxt;
      r_hb         <= w_hb_nxt;
      r_vb         <= w_vb_nxt;
      r_sel        <= w_sel_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_tvalid     <= w_tvalid_nxt;
      r_tdata      <= w_tdata_nxt;
      r_tuser      <= w_tuser_nxt;
      r_tlast      <= w_tlast_nxt;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign frame_done    = r_frame_done;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_axis_video_frame_gen.sv
// Scoreboard bench for axis_video_frame_gen: expected beats are queued per
// frame and popped by a monitor on every handshake.
module tb_axis_video_frame_gen;

  localparam int unsigned DW   = 8;
  localparam int unsigned DIMW = 12;
  localparam int unsigned BW   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [DIMW-1:0] fw = '0;
  logic [DIMW-1:0] fh = '0;
  logic [BW-1:0]   hb = '0;
  logic [BW-1:0]   vb = '0;
  logic [1:0]      sel = '0;
  logic [DW-1:0]   tdata;
  logic            tvalid, tuser, tlast;
  logic            tready = 1'b1;
  logic            fdone;
  logic [15:0]     fcnt;

  typedef struct packed {
    logic [7:0] data;
    logic       user;
    logic       last;
    logic       fin;
  } beat_t;

  beat_t q_exp[$];
  int    beat_cyc[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_beats  = 0;
  int    cyc      = 0;
  int    rdy_mode = 0;
  int    exp_fcnt = 0;
  bit    mon_en   = 1'b0;
  bit    exp_done = 1'b0;
  bit    hold_pend = 1'b0;
  beat_t hold;

  axis_video_frame_gen #(.DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .BLANK_WIDTH(BW)) dut (
    .i_sys_clk          (clk),
    .i_sys_aresetn      (rst_n),
    .en_module          (en),
    .frame_width_param  (fw),
    .frame_height_param (fh),
    .hblank_param       (hb),
    .vblank_param       (vb),
    .pattern_sel        (sel),
    .m_axis_tdata       (tdata),
    .m_axis_tvalid      (tvalid),
    .m_axis_tuser       (tuser),
    .m_axis_tlast       (tlast),
    .m_axis_tready      (tready),
    .frame_done         (fdone),
    .frame_cnt          (fcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] px(input int x, input int y, input int s, input int fc);
    case (s)
      0:       return 8'(x % 256);
      1:       return 8'(y % 256);
      2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
      default: return 8'(fc % 256);
    endcase
  endfunction

  task automatic push_frame(input int w, input int h, input int s, input int fc);
    beat_t b;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        b.data = px(x, y, s, fc);
        b.user = (x == 0) && (y == 0);
        b.last = (x == w - 1);
        b.fin  = (x == w - 1) && (y == h - 1);
        q_exp.push_back(b);
      end
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int hbl, input int vbl, input int s);
    fw  = DIMW'(w);
    fh  = DIMW'(h);
    hb  = BW'(hbl);
    vb  = BW'(vbl);
    sel = 2'(s);
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (q_exp.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, q_exp.size(), 0);
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int i = 0;
    while (n_beats < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(n_beats >= target), 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // tready driver: 0 = always ready, 1 = alternate each cycle, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshake scoreboard, hold stability and frame_done timing
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!mon_en) begin
      hold_pend = 1'b0;
      exp_done  = 1'b0;
    end else begin
      check("frame_done", 32'(fdone), 32'(exp_done));
      exp_done = 1'b0;
      if (hold_pend) begin
        check("hold_tvalid", 32'(tvalid), 1);
        check("hold_tdata", 32'(tdata), 32'(hold.data));
        check("hold_tuser", 32'(tuser), 32'(hold.user));
        check("hold_tlast", 32'(tlast), 32'(hold.last));
      end
      if (tvalid && tready) begin
        n_beats++;
        beat_cyc.push_back(cyc);
        if (q_exp.size() == 0) begin
          check("extra_beat", 32'(tvalid), 0);
        end else begin
          e = q_exp.pop_front();
          check("tdata", 32'(tdata), 32'(e.data));
          check("tuser", 32'(tuser), 32'(e.user));
          check("tlast", 32'(tlast), 32'(e.last));
          exp_done = e.fin;
        end
      end
      hold_pend = tvalid && !tready;
      hold.data = tdata;
      hold.user = tuser;
      hold.last = tlast;
      hold.fin  = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  seen;

    // Reset values
    #12;
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tuser", 32'(tuser), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_fdone", 32'(fdone), 0);
    check("rst_fcnt", 32'(fcnt), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // 4x2 horizontal ramp, no blanking, latency from en
    set_cfg(4, 2, 0, 0, 0);
    rdy_mode = 0;
    push_frame(4, 2, 0, exp_fcnt);
    start_pulse();
    @(negedge clk);
    check("latency_edge_n", 32'(tvalid), 0);
    @(negedge clk);
    check("latency_edge_n1", 32'(tvalid), 1);
    wait_drain("t1_drain", 100);
    exp_fcnt++;
    idle_cycles(3);
    check("t1_fcnt", 32'(fcnt), 32'(exp_fcnt));
    check("t1_idle", 32'(tvalid), 0);

    // Same frame under 1010 backpressure
    rdy_mode = 1;
    push_frame(4, 2, 0, exp_fcnt);
    start_pulse();
    wait_drain("t2_drain", 200);
    exp_fcnt++;
    idle_cycles(3);
    check("t2_fcnt", 32'(fcnt), 32'(exp_fcnt));

    // 3x3 vertical ramp with blanking, two frames back to back
    rdy_mode = 0;
    set_cfg(3, 3, 5, 10, 1);
    base = beat_cyc.size();
    push_frame(3, 3, 1, exp_fcnt);
    push_frame(3, 3, 1, exp_fcnt + 1);
    @(posedge clk); #1 en = 1'b1;
    wait_beats("t3_second_frame", n_beats + 10, 200);
    #1 en = 1'b0;
    wait_drain("t3_drain", 200);
    exp_fcnt += 2;
    check("t3_gap_pix", 32'(beat_cyc[base + 1] - beat_cyc[base + 0]), 1);
    check("t3_gap_h0", 32'(beat_cyc[base + 3] - beat_cyc[base + 2]), 6);
    check("t3_gap_h1", 32'(beat_cyc[base + 6] - beat_cyc[base + 5]), 6);
    check("t3_gap_v", 32'(beat_cyc[base + 9] - beat_cyc[base + 8]), 11);
    idle_cycles(15);
    check("t3_fcnt", 32'(fcnt), 32'(exp_fcnt));
    check("t3_idle", 32'(tvalid), 0);

    // en dropped during line 1 of a 4x4 frame
    set_cfg(4, 4, 1, 2, 0);
    push_frame(4, 4, 0, exp_fcnt);
    @(posedge clk); #1 en = 1'b1;
    wait_beats("t4_line1", n_beats + 5, 100);
    #1 en = 1'b0;
    wait_drain("t4_drain", 100);
    exp_fcnt++;
    idle_cycles(20);
    check("t4_idle", 32'(tvalid), 0);
    check("t4_fcnt", 32'(fcnt), 32'(exp_fcnt));

    // 16x16 checkerboard with random backpressure
    rdy_mode = 2;
    set_cfg(16, 16, 2, 0, 2);
    push_frame(16, 16, 2, exp_fcnt);
    start_pulse();
    wait_drain("t5_drain", 3000);
    exp_fcnt++;
    rdy_mode = 0;
    idle_cycles(3);
    check("t5_fcnt", 32'(fcnt), 32'(exp_fcnt));

    // Zero width never starts
    set_cfg(0, 4, 0, 0, 0);
    @(posedge clk); #1 en = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= tvalid;
    end
    en = 1'b0;
    check("w0_no_tvalid", 32'(seen), 0);

    // Flat pattern carries the completed-frame count
    set_cfg(3, 2, 0, 0, 3);
    push_frame(3, 2, 3, exp_fcnt);
    start_pulse();
    wait_drain("t6_drain", 100);
    exp_fcnt++;
    idle_cycles(3);
    check("t6_fcnt", 32'(fcnt), 32'(exp_fcnt));

    // Reset mid-line, then a clean restart from (0,0)
    set_cfg(8, 2, 0, 3, 0);
    push_frame(8, 2, 0, exp_fcnt);
    @(posedge clk); #1 en = 1'b1;
    wait_beats("t7_midline", n_beats + 3, 100);
    mon_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("mrst_tvalid", 32'(tvalid), 0);
    check("mrst_tdata", 32'(tdata), 0);
    check("mrst_tuser", 32'(tuser), 0);
    check("mrst_tlast", 32'(tlast), 0);
    check("mrst_fcnt", 32'(fcnt), 0);
    q_exp.delete();
    exp_fcnt = 0;
    @(posedge clk); #1;
    push_frame(8, 2, 0, exp_fcnt);
    mon_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_beats("t7_restart", n_beats + 1, 100);
    #1 en = 1'b0;
    wait_drain("t7_drain", 100);
    exp_fcnt++;
    idle_cycles(10);
    check("t7_fcnt", 32'(fcnt), 32'(exp_fcnt));
    check("t7_idle", 32'(tvalid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_video_frame_gen.md
Name: axis_video_frame_gen

Overview:
- AXI-Stream video frame transmitter producing the 8-bit pixel stream that the contrast/mask pipeline consumes: tuser on first pixel of frame, tlast on last pixel of each line.
- Generates programmable test patterns with configurable frame size and horizontal/vertical blanking, and honours downstream tready backpressure.
- Used as stimulus source on hardware and in system benches.

Parameters:
- DATA_WIDTH, 8, pixel width of m_axis_tdata
- DIM_WIDTH, 12, width of frame width/height counters (max 4095)
- BLANK_WIDTH, 16, width of blanking counters

Ports:
- i_sys_clk  in  1  system clock
- i_sys_aresetn  in  1  asynchronous active-low reset
- en_module  in  1  generation enable; sampled at frame boundaries
- frame_width_param  in  DIM_WIDTH  pixels per line
- frame_height_param  in  DIM_WIDTH  lines per frame
- hblank_param  in  BLANK_WIDTH  idle cycles after each non-final line
- vblank_param  in  BLANK_WIDTH  idle cycles after each frame
- pattern_sel  in  2  0 horizontal ramp, 1 vertical ramp, 2 checkerboard, 3 flat/noise
- m_axis_tdata  out  DATA_WIDTH  pixel
- m_axis_tvalid  out  1  pixel valid
- m_axis_tuser  out  1  start of frame
- m_axis_tlast  out  1  end of line
- m_axis_tready  in  1  downstream ready
- frame_done  out  1  one-cycle pulse on handshake of final pixel of frame
- frame_cnt  out  16  completed-frame counter, wraps at 0xFFFF

Behaviour:
- Reset: all outputs 0, FSM in IDLE, x/y/frame counters 0.
- Handshake: transfer when tvalid & tready. Once tvalid is high, tdata/tuser/tlast are held stable until transfer; tvalid is never dropped without a transfer. tready has no combinational path to any output; all outputs are registered.
- Params (width, height, hblank, vblank, pattern_sel) are latched in IDLE→ACTIVE transition; changes mid-frame are ignored.
- FSM:
  - IDLE: if en_module=1 and width≠0 and height≠0 → latch params, x=y=0, ACTIVE. Width or height 0 → stay IDLE.
  - ACTIVE: tvalid=1. On transfer x++. On transfer with x=width-1: x=0; if y=height-1 → frame_done pulse, frame_cnt++, go VBLANK (or directly to the frame-boundary check if vblank=0); else y++, go HBLANK (or stay ACTIVE if hblank=0).
  - HBLANK: tvalid=0; count hblank cycles, then ACTIVE.
  - VBLANK: tvalid=0; count vblank cycles, then frame-boundary check: en_module=1 → relatch params, next frame; else IDLE.
- Latency: en_module asserted before edge N in IDLE → tvalid=1 after edge N+1, i.e. one FSM cycle plus one output register.
- tuser=1 only for pixel (0,0); tlast=1 only when x=width-1. With width=1, tuser and tlast are both 1 on the first pixel.
- en_module deassert mid-frame: the current frame completes including vblank, then IDLE. No truncated frames.
- Reset mid-frame: immediate return to reset values; the next frame starts from (0,0) with tuser.
- Patterns:
  - 0: tdata=x[7:0]
  - 1: tdata=y[7:0]
  - 2: 0xFF when x[3]^y[3] else 0x00
  - 3: see optional feature
- Pattern is evaluated for the pixel being presented; the output register is loaded only when tvalid=0 or a transfer occurs.

Optional Feature:
- Macro VIDEO_GEN_NOISE_EN.
- Defined: pattern 3 = 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 0xA5 at reset and at each frame start; advances on each transfer.
- Undefined: pattern 3 = flat frame, tdata=frame_cnt[7:0] for every pixel; no LFSR logic synthesised.

Decomposition:
- Shared package video_gen_pkg: FSM state enum (IDLE, ACTIVE, HBLANK, VBLANK), pattern select enum, LFSR seed and tap constants.
- One natural sub-module: video_pattern_gen, combinational pattern from x, y, frame_cnt and pattern_sel, plus the optional LFSR register.

Test Plan:
- width=4, height=2, hblank=0, vblank=0, pattern 0, tready=1 → 8 beats with tdata 0,1,2,3,0,1,2,3; tuser on beat 0 only; tlast on beats 3 and 7; frame_done pulse coincident with beat 7; frame_cnt=1.
- Same config, tready toggled 1010… → tdata/tuser/tlast stable while tvalid & !tready; same 8-beat sequence, no drop or duplicate.
- width=3, height=3, hblank=5, vblank=10, pattern 1 → exactly 5 tvalid-low cycles after beats 2 and 5, 10 after beat 8; tdata 0,0,0,1,1,1,2,2,2.
- en_module dropped during line 1 of a 4x4 frame → all 16 beats delivered, then tvalid stays 0; frame_cnt=1.
- width=16, height=16, pattern 2 → pixel (8,0)=0xFF, (8,8)=0x00, (0,8)=0xFF; width=0 with en=1 → tvalid never asserts.
- Reset asserted mid-line → outputs 0 immediately; after release with en=1, first beat has tuser=1 and tdata=0 (pattern 0).
